// File: rtl/rpn_wan_rx_pkg.sv
// rpn_wan_rx_pkg: message encodings, header layout and FSM/class enums for the WAN RX window.
package rpn_wan_rx_pkg;
  localparam logic [7:0] MT_DATA      = 8'h01;
  localparam logic [7:0] MT_SEQ_CHECK = 8'h02;
  localparam logic [7:0] MT_SEQ_REPLY = 8'h03;
  localparam logic [7:0] MT_ACK       = 8'h04;
  localparam logic [7:0] MT_NACK      = 8'h05;
  localparam int TYPE_LSB    = 0;
  localparam int CID_LSB     = 8;
  localparam int SEQ_LSB     = 40;
  localparam int PAYLOAD_LSB = 64;
  typedef enum logic [1:0] {S_IDLE, S_CLASSIFY, S_SEND_CTRL, S_SEND_KIP} state_t;
  typedef enum logic [2:0] {CL_NEW, CL_DUP, CL_GAP, CL_STALE, CL_CHECK, CL_BAD} class_t;
endpackage

// File: rtl/rpn_wan_rx_window_if.sv
// rpn_wan_rx_window_if: AXI-Stream bundle used for the bridge input, Control output and KnownIP output.
interface rpn_wan_rx_window_if #(
  parameter int DW = 512,
  parameter int PW = 16,
  parameter int UW = 32
);
  logic            tvalid;
  logic            tready;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [PW-1:0]   tid;
  logic [PW-1:0]   tdest;
  logic [UW-1:0]   tuser;
  logic            tlast;
  modport master(output tvalid, tdata, tkeep, tid, tdest, tuser, tlast, input tready);
  modport slave(input tvalid, tdata, tkeep, tid, tdest, tuser, tlast, output tready);
endinterface

// File: rtl/rpn_wan_seq_table.sv
// rpn_wan_seq_table: direct-mapped per-sender table (valid, full-ID tag, last_seq); clear beats write.
module rpn_wan_seq_table #(
  parameter int SEQ_WIDTH        = 16,
  parameter int CLUSTER_ID_WIDTH = 32,
  parameter int TABLE_IDX_WIDTH  = 4
)(
  input  logic                        i_clk,
  input  logic                        i_ap_rst,
  input  logic                        i_clear,
  input  logic [CLUSTER_ID_WIDTH-1:0] i_rd_id,
  output logic                        o_hit,
  output logic [SEQ_WIDTH-1:0]        o_last_seq,
  input  logic                        i_we,
  input  logic [CLUSTER_ID_WIDTH-1:0] i_wr_id,
  input  logic [SEQ_WIDTH-1:0]        i_wr_seq
);
  localparam int N = 1 << TABLE_IDX_WIDTH;
  logic [N-1:0]                r_valid;
  logic [CLUSTER_ID_WIDTH-1:0] r_tag  [N];
  logic [SEQ_WIDTH-1:0]        r_last [N];
  logic [TABLE_IDX_WIDTH-1:0]  w_rd_idx, w_wr_idx;
  assign w_rd_idx   = i_rd_id[TABLE_IDX_WIDTH-1:0];
  assign w_wr_idx   = i_wr_id[TABLE_IDX_WIDTH-1:0];
  assign o_hit      = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == i_rd_id);
  assign o_last_seq = r_last[w_rd_idx];
  always_ff @(posedge i_clk or posedge i_ap_rst)
    if (i_ap_rst) r_valid <= '0;
    else if (i_clear) r_valid <= '0;
    else if (i_we) r_valid[w_wr_idx] <= 1'b1;
  // Tag/seq need no reset: they are only observed behind a valid bit.
  always_ff @(posedge i_clk)
    if (i_we) begin
      r_tag[w_wr_idx]  <= i_wr_id;
      r_last[w_wr_idx] <= i_wr_seq;
    end
endmodule

// File: rtl/rpn_wan_rx_window.sv
// rpn_wan_rx_window: WAN reliability receiver; classifies messages by sequence distance, delivers/ACKs/answers.
// Optional RPN_WAN_RX_NACK_EN: gaps are NACKed with the expected sequence instead of dropped.
module rpn_wan_rx_window
  import rpn_wan_rx_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int SEQ_WIDTH        = 16,
  parameter int CLUSTER_ID_WIDTH = 32,
  parameter int TABLE_IDX_WIDTH  = 4,
  parameter int DUP_WINDOW       = 8,
  parameter int IP_ADDRESS_WIDTH = 32,
  parameter int IP_PORT_WIDTH    = 16,
  parameter int MSG_TYPE_WIDTH   = 8
)(
  input  logic                        i_clk,
  input  logic                        i_ap_rst,
  input  logic [CLUSTER_ID_WIDTH-1:0] i_cluster_id,
  input  logic [IP_PORT_WIDTH-1:0]    i_KIP_port_number,
  input  logic                        i_table_clear,
  rpn_wan_rx_window_if.slave          from_nb,
  rpn_wan_rx_window_if.master         to_ctrl,
  rpn_wan_rx_window_if.master         to_nb_KIP
);
  localparam int DW  = AXIS_DATA_WIDTH;
  localparam int PLW = DW - PAYLOAD_LSB;
  localparam logic [SEQ_WIDTH:0] DUP_LO = {1'b1, {SEQ_WIDTH{1'b0}}} - (SEQ_WIDTH+1)'(DUP_WINDOW - 1);
  state_t                              r_state;
  logic                                r_nb_ready, r_ctrl_valid, r_kip_valid;
  logic [MSG_TYPE_WIDTH-1:0]           r_type;
  logic [CLUSTER_ID_WIDTH-1:0]         r_id;
  logic [SEQ_WIDTH-1:0]                r_seq;
  logic [PLW-1:0]                      r_payload;
  logic [DW/8-1:0]                     r_keep;
  logic [IP_PORT_WIDTH-1:0]            r_tid, r_tdest;
  logic [IP_ADDRESS_WIDTH-1:0]         r_tuser;
  logic [DW-1:0]                       r_kip_data, w_kip_data;
  logic [IP_ADDRESS_WIDTH+2*IP_PORT_WIDTH-1:0] r_kip_user;
  logic                                w_hit, w_dup, w_gap, w_to_kip, w_unused;
  logic [SEQ_WIDTH-1:0]                w_last, w_d, w_kip_seq;
  logic [MSG_TYPE_WIDTH-1:0]           w_kip_type;
  class_t                              w_class;
  rpn_wan_seq_table #(
    .SEQ_WIDTH(SEQ_WIDTH), .CLUSTER_ID_WIDTH(CLUSTER_ID_WIDTH), .TABLE_IDX_WIDTH(TABLE_IDX_WIDTH)
  ) u_table (
    .i_clk(i_clk), .i_ap_rst(i_ap_rst), .i_clear(i_table_clear),
    .i_rd_id(r_id), .o_hit(w_hit), .o_last_seq(w_last),
    .i_we(r_state == S_CLASSIFY && w_class == CL_NEW), .i_wr_id(r_id), .i_wr_seq(r_seq)
  );
  assign w_d   = r_seq - w_last;
  assign w_dup = (w_d == '0) || ({1'b0, w_d} >= DUP_LO);
  assign w_gap = (w_d > SEQ_WIDTH'(1)) && !w_d[SEQ_WIDTH-1] && !w_dup;
  assign w_class = r_type == MSG_TYPE_WIDTH'(MT_SEQ_CHECK) ? CL_CHECK :
                   r_type != MSG_TYPE_WIDTH'(MT_DATA)      ? CL_BAD   :
                   (!w_hit || w_d == SEQ_WIDTH'(1))        ? CL_NEW   :
                   w_dup ? CL_DUP : w_gap ? CL_GAP : CL_STALE;
`ifdef RPN_WAN_RX_NACK_EN
  assign w_to_kip = w_class inside {CL_DUP, CL_GAP, CL_CHECK};
`else
  assign w_to_kip = w_class inside {CL_DUP, CL_CHECK};
`endif
  assign w_kip_seq  = w_class == CL_GAP   ? w_last + SEQ_WIDTH'(1) :
                      w_class == CL_CHECK ? (w_hit ? w_last : '1) : r_seq;
  assign w_kip_type = w_class == CL_GAP   ? MSG_TYPE_WIDTH'(MT_NACK) :
                      w_class == CL_CHECK ? MSG_TYPE_WIDTH'(MT_SEQ_REPLY) : MSG_TYPE_WIDTH'(MT_ACK);
  always_comb begin
    w_kip_data = '0;
    w_kip_data[TYPE_LSB +: MSG_TYPE_WIDTH]  = w_kip_type;
    w_kip_data[CID_LSB +: CLUSTER_ID_WIDTH] = i_cluster_id;
    w_kip_data[SEQ_LSB +: SEQ_WIDTH]        = w_kip_seq;
  end
  // Ready is re-raised one cycle after returning to IDLE, bounding throughput at one message per 3 cycles.
  always_ff @(posedge i_clk or posedge i_ap_rst)
    if (i_ap_rst) begin
      r_state <= S_IDLE;
      r_nb_ready <= 1'b0;
      r_ctrl_valid <= 1'b0;
      r_kip_valid <= 1'b0;
      r_type <= '0;
      r_id <= '0;
      r_seq <= '0;
      r_payload <= '0;
      r_keep <= '0;
      r_tid <= '0;
      r_tdest <= '0;
      r_tuser <= '0;
      r_kip_data <= '0;
      r_kip_user <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (!r_nb_ready) r_nb_ready <= 1'b1;
          else if (from_nb.tvalid) begin
            r_nb_ready <= 1'b0;
            r_type <= from_nb.tdata[TYPE_LSB +: MSG_TYPE_WIDTH];
            r_id <= from_nb.tdata[CID_LSB +: CLUSTER_ID_WIDTH];
            r_seq <= from_nb.tdata[SEQ_LSB +: SEQ_WIDTH];
            r_payload <= from_nb.tdata[DW-1:PAYLOAD_LSB];
            r_keep <= from_nb.tkeep;
            r_tid <= from_nb.tid;
            r_tdest <= from_nb.tdest;
            r_tuser <= from_nb.tuser;
            r_state <= S_CLASSIFY;
          end
        S_CLASSIFY: begin
          r_kip_data <= w_kip_data;
          r_kip_user <= {i_KIP_port_number, i_KIP_port_number, r_tuser};
          r_ctrl_valid <= w_class == CL_NEW;
          r_kip_valid <= w_class != CL_NEW && w_to_kip;
          r_state <= w_class == CL_NEW ? S_SEND_CTRL : w_to_kip ? S_SEND_KIP : S_IDLE;
        end
        S_SEND_CTRL:
          if (to_ctrl.tready) begin
            r_ctrl_valid <= 1'b0;
            r_kip_valid <= 1'b1;
            r_state <= S_SEND_KIP;
          end
        default:
          if (to_nb_KIP.tready) begin
            r_kip_valid <= 1'b0;
            r_state <= S_IDLE;
          end
      endcase
    end
  assign from_nb.tready   = r_nb_ready;
  assign to_ctrl.tvalid   = r_ctrl_valid;
  assign to_ctrl.tdata    = {{PAYLOAD_LSB{1'b0}}, r_payload};
  assign to_ctrl.tkeep    = r_keep;
  assign to_ctrl.tid      = r_tid;
  assign to_ctrl.tdest    = r_tdest;
  assign to_ctrl.tuser    = r_tuser;
  assign to_ctrl.tlast    = 1'b1;
  assign to_nb_KIP.tvalid = r_kip_valid;
  assign to_nb_KIP.tdata  = r_kip_data;
  assign to_nb_KIP.tkeep  = '1;
  assign to_nb_KIP.tid    = '0;
  assign to_nb_KIP.tdest  = '0;
  assign to_nb_KIP.tuser  = r_kip_user;
  assign to_nb_KIP.tlast  = 1'b1;
  assign w_unused = ^{from_nb.tlast, from_nb.tdata[PAYLOAD_LSB-1:SEQ_LSB+SEQ_WIDTH]};
endmodule

// File: tb/tb_rpn_wan_rx_window.sv
// tb_rpn_wan_rx_window: directed and randomized checks of the WAN RX window against a table model.
module tb_rpn_wan_rx_window;
  localparam int DUP_WINDOW = 8;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        table_clear = 1'b0;
  logic [31:0] cluster_id = 32'hC0DE_0001;
  logic [15:0] kip_port = 16'd4791;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  rpn_wan_rx_window_if #(.DW(512), .PW(16), .UW(32)) from_nb();
  rpn_wan_rx_window_if #(.DW(512), .PW(16), .UW(32)) to_ctrl();
  rpn_wan_rx_window_if #(.DW(512), .PW(16), .UW(64)) kip();

  rpn_wan_rx_window dut (
    .i_clk(clk), .i_ap_rst(rst), .i_cluster_id(cluster_id), .i_KIP_port_number(kip_port),
    .i_table_clear(table_clear), .from_nb(from_nb), .to_ctrl(to_ctrl), .to_nb_KIP(kip)
  );

  // stimulus words for the next message and what the last transaction produced
  logic [511:0] s_data, sent;
  logic [63:0]  s_keep;
  logic [15:0]  s_tid, s_tdest;
  logic [31:0]  s_ip;
  bit           o_to;
  int           o_nctrl, o_nkip, o_ctrl_at, o_kip_at;
  logic [511:0] o_cdata, o_kdata;
  logic [63:0]  o_ckeep, o_kuser;
  logic [15:0]  o_ctid, o_ctdest;
  logic [31:0]  o_cuser;

  // reference table
  bit          mv [16];
  logic [31:0] mtag [16];
  int          mlast [16];

  function automatic logic [511:0] kword(input logic [7:0] t, input logic [15:0] s);
    logic [511:0] w = '0;
    w[7:0] = t;
    w[39:8] = cluster_id;
    w[55:40] = s;
    return w;
  endfunction

  task automatic randomize_stim();
    for (int k = 0; k < 16; k++) s_data[32*k +: 32] = $urandom;
    s_keep = {$urandom, $urandom};
    s_tid = 16'($urandom);
    s_tdest = 16'($urandom);
    s_ip = $urandom;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 0;
  endtask

  task automatic model(input logic [7:0] ty, input logic [31:0] id, input int seq,
                       output bit deliver, output bit kip_en, output logic [7:0] kty, output int kseq);
    int i = int'(id % 16);
    bit hit = mv[i] && mtag[i] == id;
    int d;
    deliver = 0; kip_en = 0; kty = 0; kseq = 0;
    if (ty == 8'h02) begin
      kip_en = 1; kty = 8'h03; kseq = hit ? mlast[i] : 65535;
    end else if (ty == 8'h01) begin
      d = hit ? (seq - mlast[i] + 65536) % 65536 : 1;
      if (d == 1) begin
        deliver = 1; kip_en = 1; kty = 8'h04; kseq = seq;
        mv[i] = 1; mtag[i] = id; mlast[i] = seq;
      end else if (d == 0 || d >= 65536 - (DUP_WINDOW - 1)) begin
        kip_en = 1; kty = 8'h04; kseq = seq;
      end else if (d < 32768) begin
`ifdef RPN_WAN_RX_NACK_EN
        kip_en = 1; kty = 8'h05; kseq = (mlast[i] + 1) % 65536;
`endif
      end
    end
  endtask

  // Sends one message with all sinks ready and records every output beat until the input is ready again.
  task automatic xact(input logic [7:0] ty, input logic [31:0] id, input logic [15:0] seq, input bit clr);
    int w = 0;
    o_to = 0; o_nctrl = 0; o_nkip = 0; o_ctrl_at = -1; o_kip_at = -1;
    while (!from_nb.tready && w < 20) begin @(negedge clk); w++; end
    if (!from_nb.tready) begin o_to = 1; return; end
    sent = s_data;
    sent[7:0] = ty;
    sent[39:8] = id;
    sent[55:40] = seq;
    from_nb.tdata = sent; from_nb.tkeep = s_keep; from_nb.tid = s_tid;
    from_nb.tdest = s_tdest; from_nb.tuser = s_ip; from_nb.tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    from_nb.tvalid = 1'b0;
    table_clear = clr;
    for (int c = 0; c < 20; c++) begin
      if (c == 1) table_clear = 1'b0;
      if (to_ctrl.tvalid) begin
        if (o_nctrl == 0) begin
          o_ctrl_at = c; o_cdata = to_ctrl.tdata; o_ckeep = to_ctrl.tkeep;
          o_ctid = to_ctrl.tid; o_ctdest = to_ctrl.tdest; o_cuser = to_ctrl.tuser;
        end
        o_nctrl++;
      end
      if (kip.tvalid) begin
        if (o_nkip == 0) begin o_kip_at = c; o_kdata = kip.tdata; o_kuser = kip.tuser; end
        o_nkip++;
      end
      if (from_nb.tready) return;
      @(negedge clk);
    end
    o_to = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (from_nb.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b exp 0", from_nb.tready); end
    checks++; if (to_ctrl.tvalid !== 1'b0) begin errors++; $display("FAIL reset_ctrl_valid got %b exp 0", to_ctrl.tvalid); end
    checks++; if (kip.tvalid !== 1'b0) begin errors++; $display("FAIL reset_kip_valid got %b exp 0", kip.tvalid); end
    checks++; if (to_ctrl.tdata !== '0) begin errors++; $display("FAIL reset_ctrl_data got %h exp 0", to_ctrl.tdata); end
    checks++; if (kip.tdata !== '0) begin errors++; $display("FAIL reset_kip_data got %h exp 0", kip.tdata); end
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_new_dup();
    randomize_stim();
    xact(8'h01, 32'h5, 16'd7, 0);
    checks++; if (o_to !== 0) begin errors++; $display("FAIL new_timeout got %0d exp 0", o_to); end
    checks++; if (o_nctrl !== 1 || o_ctrl_at !== 1) begin errors++; $display("FAIL new_ctrl_beats got %0d@%0d exp 1@1", o_nctrl, o_ctrl_at); end
    checks++; if (o_cdata !== (sent >> 64)) begin errors++; $display("FAIL new_ctrl_data got %h exp %h", o_cdata, sent >> 64); end
    checks++; if ({o_ckeep, o_ctid, o_ctdest, o_cuser} !== {s_keep, s_tid, s_tdest, s_ip}) begin
      errors++; $display("FAIL new_ctrl_side got %h exp %h", {o_ckeep, o_ctid, o_ctdest, o_cuser}, {s_keep, s_tid, s_tdest, s_ip}); end
    checks++; if (o_nkip !== 1 || o_kip_at !== 2) begin errors++; $display("FAIL new_kip_beats got %0d@%0d exp 1@2", o_nkip, o_kip_at); end
    checks++; if (o_kdata !== kword(8'h04, 16'd7)) begin errors++; $display("FAIL new_ack got %h exp %h", o_kdata, kword(8'h04, 16'd7)); end
    checks++; if (o_kuser !== {kip_port, kip_port, s_ip}) begin errors++; $display("FAIL new_kip_user got %h exp %h", o_kuser, {kip_port, kip_port, s_ip}); end
    randomize_stim();
    xact(8'h01, 32'h5, 16'd7, 0);
    checks++; if (o_nctrl !== 0) begin errors++; $display("FAIL dup_ctrl_beats got %0d exp 0", o_nctrl); end
    checks++; if (o_nkip !== 1 || o_kip_at !== 1) begin errors++; $display("FAIL dup_kip_beats got %0d@%0d exp 1@1", o_nkip, o_kip_at); end
    checks++; if (o_kdata !== kword(8'h04, 16'd7)) begin errors++; $display("FAIL dup_ack got %h exp %h", o_kdata, kword(8'h04, 16'd7)); end
  endtask

  task automatic test_wrap();
    randomize_stim();
    xact(8'h01, 32'h23, 16'hFFFF, 0);
    randomize_stim();
    xact(8'h01, 32'h23, 16'h0000, 0);
    checks++; if (o_nctrl !== 1) begin errors++; $display("FAIL wrap_ctrl_beats got %0d exp 1", o_nctrl); end
    checks++; if (o_kdata !== kword(8'h04, 16'h0)) begin errors++; $display("FAIL wrap_ack got %h exp %h", o_kdata, kword(8'h04, 16'h0)); end
    xact(8'h02, 32'h23, 16'h1234, 0);
    checks++; if (o_kdata !== kword(8'h03, 16'h0)) begin errors++; $display("FAIL wrap_table got %h exp %h", o_kdata, kword(8'h03, 16'h0)); end
  endtask

  task automatic test_gap_window();
    randomize_stim();
    xact(8'h01, 32'h4A, 16'd10, 0);
    xact(8'h01, 32'h4A, 16'd13, 0);
    checks++; if (o_nctrl !== 0) begin errors++; $display("FAIL gap_ctrl_beats got %0d exp 0", o_nctrl); end
`ifdef RPN_WAN_RX_NACK_EN
    checks++; if (o_nkip !== 1 || o_kdata !== kword(8'h05, 16'd11)) begin
      errors++; $display("FAIL gap_nack got %0d beats %h exp 1 beat %h", o_nkip, o_kdata, kword(8'h05, 16'd11)); end
`else
    checks++; if (o_nkip !== 0) begin errors++; $display("FAIL gap_dropped got %0d beats exp 0", o_nkip); end
`endif
    xact(8'h01, 32'h4A, 16'd3, 0);
    checks++; if (o_nctrl !== 0 || o_nkip !== 1 || o_kdata !== kword(8'h04, 16'd3)) begin
      errors++; $display("FAIL dup_edge got %0d/%0d %h exp 0/1 %h", o_nctrl, o_nkip, o_kdata, kword(8'h04, 16'd3)); end
    xact(8'h01, 32'h4A, 16'd2, 0);
    checks++; if (o_nctrl !== 0 || o_nkip !== 0 || o_to !== 0) begin
      errors++; $display("FAIL stale got %0d/%0d to=%0d exp 0/0 to=0", o_nctrl, o_nkip, o_to); end
    xact(8'h02, 32'h4A, 16'd0, 0);
    checks++; if (o_kdata !== kword(8'h03, 16'd10)) begin errors++; $display("FAIL gap_table got %h exp %h", o_kdata, kword(8'h03, 16'd10)); end
  endtask

  task automatic test_seq_check();
    randomize_stim();
    xact(8'h02, 32'h77, 16'd0, 0);
    checks++; if (o_nkip !== 1 || o_kip_at !== 1 || o_kdata !== kword(8'h03, 16'hFFFF)) begin
      errors++; $display("FAIL check_miss got %0d@%0d %h exp 1@1 %h", o_nkip, o_kip_at, o_kdata, kword(8'h03, 16'hFFFF)); end
    xact(8'h01, 32'h77, 16'd4, 0);
    xact(8'h02, 32'h77, 16'd0, 0);
    checks++; if (o_kdata !== kword(8'h03, 16'd4)) begin errors++; $display("FAIL check_hit got %h exp %h", o_kdata, kword(8'h03, 16'd4)); end
    xact(8'h02, 32'h87, 16'd0, 0);
    checks++; if (o_kdata !== kword(8'h03, 16'hFFFF)) begin errors++; $display("FAIL check_alias got %h exp %h", o_kdata, kword(8'h03, 16'hFFFF)); end
    xact(8'h09, 32'h77, 16'd5, 0);
    checks++; if (o_nctrl !== 0 || o_nkip !== 0 || o_to !== 0) begin
      errors++; $display("FAIL unknown_type got %0d/%0d to=%0d exp 0/0 to=0", o_nctrl, o_nkip, o_to); end
  endtask

  task automatic test_clear_in_classify();
    randomize_stim();
    xact(8'h01, 32'h3C, 16'd100, 1);
    checks++; if (o_nctrl !== 1 || o_kdata !== kword(8'h04, 16'd100)) begin
      errors++; $display("FAIL clr_classify got %0d %h exp 1 %h", o_nctrl, o_kdata, kword(8'h04, 16'd100)); end
    xact(8'h02, 32'h3C, 16'd0, 0);
    checks++; if (o_kdata !== kword(8'h03, 16'hFFFF)) begin errors++; $display("FAIL clr_commit got %h exp %h", o_kdata, kword(8'h03, 16'hFFFF)); end
    model_clear();
  endtask

  task automatic test_backpressure_reset();
    int w = 0;
    logic [511:0] snap;
    randomize_stim();
    sent = s_data;
    sent[7:0] = 8'h01; sent[39:8] = 32'h11; sent[55:40] = 16'd50;
    while (!from_nb.tready && w < 20) begin @(negedge clk); w++; end
    from_nb.tdata = sent; from_nb.tkeep = s_keep; from_nb.tid = s_tid;
    from_nb.tdest = s_tdest; from_nb.tuser = s_ip; from_nb.tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    from_nb.tvalid = 1'b0;
    to_ctrl.tready = 1'b0;
    w = 0;
    while (!to_ctrl.tvalid && w < 10) begin @(negedge clk); w++; end
    checks++; if (to_ctrl.tvalid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got %b exp 1", to_ctrl.tvalid); end
    snap = to_ctrl.tdata;
    checks++; if (snap !== (sent >> 64)) begin errors++; $display("FAIL bp_data got %h exp %h", snap, sent >> 64); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (to_ctrl.tvalid !== 1'b1 || to_ctrl.tdata !== snap || from_nb.tready !== 1'b0 || kip.tvalid !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d got v=%b rdy=%b kv=%b exp v=1 rdy=0 kv=0", c, to_ctrl.tvalid, from_nb.tready, kip.tvalid); end
    end
    rst = 1'b1;
    #1;
    checks++; if ({to_ctrl.tvalid, kip.tvalid, from_nb.tready} !== 3'b000 || to_ctrl.tdata !== '0) begin
      errors++; $display("FAIL midreset got %b data %h exp 000 data 0", {to_ctrl.tvalid, kip.tvalid, from_nb.tready}, to_ctrl.tdata); end
    @(negedge clk);
    rst = 1'b0;
    to_ctrl.tready = 1'b1;
    model_clear();
    xact(8'h02, 32'h11, 16'd0, 0);
    checks++; if (o_nctrl !== 0 || o_kdata !== kword(8'h03, 16'hFFFF)) begin
      errors++; $display("FAIL midreset_table got %0d %h exp 0 %h", o_nctrl, o_kdata, kword(8'h03, 16'hFFFF)); end
  endtask

  task automatic test_random();
    logic [31:0] pool [5] = '{32'h5, 32'h15, 32'h7, 32'h27, 32'h9};
    table_clear = 1'b1;
    @(negedge clk);
    table_clear = 1'b0;
    model_clear();
    for (int n = 0; n < 120; n++) begin
      logic [31:0] id = pool[$urandom_range(0, 4)];
      int i = int'(id % 16);
      int r = $urandom_range(0, 99);
      logic [7:0] ty = r < 70 ? 8'h01 : r < 90 ? 8'h02 : 8'($urandom_range(3, 9));
      int seq = (mv[i] && mtag[i] == id && $urandom_range(0, 15) != 0)
                ? (mlast[i] + $urandom_range(0, 20) - 12 + 65536) % 65536 : $urandom_range(0, 65535);
      bit deliver, kip_en;
      logic [7:0] kty;
      int kseq;
      if ($urandom_range(0, 24) == 0) begin
        table_clear = 1'b1;
        @(negedge clk);
        table_clear = 1'b0;
        model_clear();
      end
      randomize_stim();
      model(ty, id, seq, deliver, kip_en, kty, kseq);
      xact(ty, id, 16'(seq), 0);
      checks++; if (o_to !== 0 || o_nctrl !== int'(deliver) || o_nkip !== int'(kip_en)) begin
        errors++; $display("FAIL rnd%0d beats ty=%h id=%h seq=%0d got %0d/%0d to=%0d exp %0d/%0d", n, ty, id, seq, o_nctrl, o_nkip, o_to, deliver, kip_en); end
      if (deliver && o_nctrl > 0) begin
        checks++; if (o_cdata !== (sent >> 64) || o_cuser !== s_ip || o_ckeep !== s_keep) begin
          errors++; $display("FAIL rnd%0d ctrl got %h exp %h", n, o_cdata, sent >> 64); end
      end
      if (kip_en && o_nkip > 0) begin
        checks++; if (o_kdata !== kword(kty, 16'(kseq)) || o_kuser !== {kip_port, kip_port, s_ip}) begin
          errors++; $display("FAIL rnd%0d kip got %h exp %h", n, o_kdata, kword(kty, 16'(kseq))); end
      end
    end
  endtask

  initial begin
    from_nb.tvalid = 1'b0; from_nb.tdata = '0; from_nb.tkeep = '0; from_nb.tid = '0;
    from_nb.tdest = '0; from_nb.tuser = '0; from_nb.tlast = 1'b1;
    to_ctrl.tready = 1'b1;
    kip.tready = 1'b1;
    #2;
    test_reset();
    test_new_dup();
    test_wrap();
    test_gap_window();
    test_seq_check();
    test_clear_in_classify();
    test_backpressure_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
